// File: rtl/upb_qdr_req_sched.sv
// QDR-II request scheduler: arbitrates write/read requests onto one PHY command register
// and returns read data in order via a credit-protected FIFO. Optional stats: UPB_QDR_SCHED_STATS_EN.
module upb_qdr_req_sched #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 144,
    parameter int RET_DEPTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_valid_i,
    output logic              rd_ready_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rdret_valid_o,
    input  logic              rdret_ready_i,
    output logic [DATA_W-1:0] rdret_data_o,
    output logic              phy_cmd_valid_o,
    input  logic              phy_cmd_ready_i,
    output logic              phy_cmd_wr_o,
    output logic [ADDR_W-1:0] phy_cmd_addr_o,
    output logic [DATA_W-1:0] phy_cmd_data_o,
    input  logic              phy_rd_vld_i,
    input  logic [DATA_W-1:0] phy_rd_data_i,
    output logic              err_unexp_o
`ifdef UPB_QDR_SCHED_STATS_EN
    ,
    output logic [31:0]       stat_wr_cmds_o,
    output logic [31:0]       stat_rd_cmds_o,
    output logic [31:0]       stat_credit_stall_o
`endif
);

    localparam int PTR_W = $clog2(RET_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W+1:0] DEPTH_L = (CNT_W+2)'(RET_DEPTH);

    logic              cmdValid_q, cmdValid_d;
    logic              cmdWr_q, cmdWr_d;
    logic [ADDR_W-1:0] cmdAddr_q;
    logic [DATA_W-1:0] cmdData_q;
    logic              lastGrant_q, lastGrant_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  fifoCount_q, fifoCount_d;
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic              errUnexp_q, errUnexp_d;
    logic [DATA_W-1:0] retMem [RET_DEPTH];

    logic              loadable;
    logic [CNT_W+1:0]  creditSum;
    logic              hasCredit;
    logic              rdEligible;
    logic              wrFire;
    logic              rdFire;
    logic              contested;
    logic              rdIssue;
    logic              retOk;
    logic              push;
    logic              pop;

    // Arbitration: lastGrant_q=1 means the previous contest went to the write, so the read is next.
    always_comb begin
        loadable   = ~cmdValid_q | phy_cmd_ready_i;
        creditSum  = {2'b00, outstanding_q} + {2'b00, fifoCount_q}
                   + (CNT_W+2)'(cmdValid_q & ~cmdWr_q);
        hasCredit  = creditSum < DEPTH_L;
        rdEligible = rd_valid_i & hasCredit;
        wr_ready_o = rst_ni & loadable & ~(rdEligible & lastGrant_q);
        rd_ready_o = rst_ni & loadable & hasCredit & ~(wr_valid_i & ~lastGrant_q);
        wrFire     = wr_valid_i & wr_ready_o;
        rdFire     = rd_valid_i & rd_ready_o;
        contested  = loadable & wr_valid_i & rdEligible;
        rdIssue    = cmdValid_q & ~cmdWr_q & phy_cmd_ready_i;
        retOk      = phy_rd_vld_i & (outstanding_q != '0);
        push       = retOk;
        pop        = rdret_valid_o & rdret_ready_i;
    end

    always_comb begin
        cmdValid_d    = cmdValid_q;
        cmdWr_d       = cmdWr_q;
        lastGrant_d   = lastGrant_q;
        outstanding_d = outstanding_q;
        fifoCount_d   = fifoCount_q;
        wrPtr_d       = wrPtr_q;
        rdPtr_d       = rdPtr_q;
        errUnexp_d    = errUnexp_q | (phy_rd_vld_i & (outstanding_q == '0));

        if (loadable) begin
            cmdValid_d = wrFire | rdFire;
            if (wrFire | rdFire) begin
                cmdWr_d = wrFire;
            end
        end
        if (contested) begin
            lastGrant_d = ~lastGrant_q;
        end

        case ({rdIssue, retOk})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        case ({push, pop})
            2'b10:   fifoCount_d = fifoCount_q + CNT_W'(1);
            2'b01:   fifoCount_d = fifoCount_q - CNT_W'(1);
            default: fifoCount_d = fifoCount_q;
        endcase

        if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmdValid_q    <= 1'b0;
            cmdWr_q       <= 1'b0;
            lastGrant_q   <= 1'b0;
            outstanding_q <= '0;
            fifoCount_q   <= '0;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            errUnexp_q    <= 1'b0;
        end else begin
            cmdValid_q    <= cmdValid_d;
            cmdWr_q       <= cmdWr_d;
            lastGrant_q   <= lastGrant_d;
            outstanding_q <= outstanding_d;
            fifoCount_q   <= fifoCount_d;
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            errUnexp_q    <= errUnexp_d;
        end
    end

    // Payload registers carry no reset; they are only observed while qualified by a valid.
    always_ff @(posedge clk_i) begin
        if (wrFire) begin
            cmdAddr_q <= wr_addr_i;
            cmdData_q <= wr_data_i;
        end else if (rdFire) begin
            cmdAddr_q <= rd_addr_i;
        end
        if (push) begin
            retMem[wrPtr_q] <= phy_rd_data_i;
        end
    end

    assign phy_cmd_valid_o = cmdValid_q;
    assign phy_cmd_wr_o    = cmdWr_q;
    assign phy_cmd_addr_o  = cmdAddr_q;
    assign phy_cmd_data_o  = cmdData_q;
    assign rdret_valid_o   = fifoCount_q != '0;
    assign rdret_data_o    = retMem[rdPtr_q];
    assign err_unexp_o     = errUnexp_q;

`ifdef UPB_QDR_SCHED_STATS_EN
    logic [31:0] statWr_q, statRd_q, statStall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            statWr_q    <= '0;
            statRd_q    <= '0;
            statStall_q <= '0;
        end else begin
            if (wrFire) begin
                statWr_q <= statWr_q + 32'd1;
            end
            if (rdFire) begin
                statRd_q <= statRd_q + 32'd1;
            end
            if (rd_valid_i & ~hasCredit) begin
                statStall_q <= statStall_q + 32'd1;
            end
        end
    end

    assign stat_wr_cmds_o      = statWr_q;
    assign stat_rd_cmds_o      = statRd_q;
    assign stat_credit_stall_o = statStall_q;
`endif

endmodule

// File: tb/tb_upb_qdr_req_sched.sv
// Self-checking bench for upb_qdr_req_sched: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations on PHY order, credit limits and reset.
module tb_upb_qdr_req_sched;

    localparam int AW    = 19;
    localparam int DW    = 144;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wrValid, wrReady, rdValid, rdReady;
    logic [AW-1:0] wrAddr, rdAddr;
    logic [DW-1:0] wrData;
    logic          rdretValid, rdretReady;
    logic [DW-1:0] rdretData;
    logic          phyCmdValid, phyCmdReady, phyCmdWr;
    logic [AW-1:0] phyCmdAddr;
    logic [DW-1:0] phyCmdData;
    logic          phyRdVld;
    logic [DW-1:0] phyRdData;
    logic          errUnexp;

    always #5 clk = ~clk;

    upb_qdr_req_sched #(.ADDR_W(AW), .DATA_W(DW), .RET_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wr_valid_i(wrValid), .wr_ready_o(wrReady), .wr_addr_i(wrAddr), .wr_data_i(wrData),
        .rd_valid_i(rdValid), .rd_ready_o(rdReady), .rd_addr_i(rdAddr),
        .rdret_valid_o(rdretValid), .rdret_ready_i(rdretReady), .rdret_data_o(rdretData),
        .phy_cmd_valid_o(phyCmdValid), .phy_cmd_ready_i(phyCmdReady), .phy_cmd_wr_o(phyCmdWr),
        .phy_cmd_addr_o(phyCmdAddr), .phy_cmd_data_o(phyCmdData),
        .phy_rd_vld_i(phyRdVld), .phy_rd_data_i(phyRdData),
        .err_unexp_o(errUnexp)
    );

    int passCnt  = 0;
    int totalCnt = 0;
    int cyc      = 0;

    // Reference model: abstract occupancy of the command slot, outstanding reads and a data queue.
    bit            mCmdValid, mCmdWr, mWrNext, mErr;
    logic [AW-1:0] mCmdAddr;
    logic [DW-1:0] mCmdData;
    int            mOut;
    logic [DW-1:0] mFifo[$];
    bit            mLoad, mCredit, mRdElig, mExpWr, mExpRd, mWrAcc, mRdAcc, mIssueRd;

    bit            logWr[$];
    logic [AW-1:0] logAddr[$];
    int            logCyc[$];

    function automatic logic [DW-1:0] pat(input int unsigned k);
        logic [31:0] kk;
        kk = k;
        return {kk[15:0], 32'hA5A50000 ^ kk, ~kk, kk * 32'd3, kk ^ 32'h5A5A5A5A};
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit wv, input int wa, input bit rv, input int ra);
        wrValid = wv;
        wrAddr  = AW'(wa);
        wrData  = pat(wa);
        rdValid = rv;
        rdAddr  = AW'(ra);
        tick();
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            mCmdValid = 0; mCmdWr = 0; mWrNext = 1; mErr = 0; mOut = 0;
            mFifo.delete();
            checkOutput("rst_wr_ready", wrReady, 0);
            checkOutput("rst_rd_ready", rdReady, 0);
            checkOutput("rst_cmd_valid", phyCmdValid, 0);
            checkOutput("rst_rdret_valid", rdretValid, 0);
            checkOutput("rst_err", errUnexp, 0);
        end else begin
            mLoad   = !mCmdValid || phyCmdReady;
            mCredit = (mOut + mFifo.size() + ((mCmdValid && !mCmdWr) ? 1 : 0)) < DEPTH;
            mRdElig = rdValid && mCredit;
            mExpWr  = mLoad && !(mRdElig && !mWrNext);
            mExpRd  = mLoad && mCredit && !(wrValid && mWrNext);

            checkOutput("wr_ready", wrReady, mExpWr);
            checkOutput("rd_ready", rdReady, mExpRd);
            checkOutput("cmd_valid", phyCmdValid, mCmdValid);
            if (mCmdValid) begin
                checkOutput("cmd_wr", phyCmdWr, mCmdWr);
                checkOutput("cmd_addr", phyCmdAddr, mCmdAddr);
                if (mCmdWr) checkOutput("cmd_data", phyCmdData, mCmdData);
            end
            checkOutput("rdret_valid", rdretValid, mFifo.size() != 0);
            if (mFifo.size() != 0) checkOutput("rdret_data", rdretData, mFifo[0]);
            checkOutput("err_unexp", errUnexp, mErr);

            if (phyCmdValid && phyCmdReady) begin
                logWr.push_back(phyCmdWr);
                logAddr.push_back(phyCmdAddr);
                logCyc.push_back(cyc);
            end

            mWrAcc   = wrValid && mExpWr;
            mRdAcc   = rdValid && mExpRd;
            mIssueRd = mCmdValid && !mCmdWr && phyCmdReady;
            if (wrValid && mRdElig && mLoad) mWrNext = !mWrNext;
            if (rdretReady && mFifo.size() != 0) void'(mFifo.pop_front());
            if (phyRdVld) begin
                if (mOut == 0) mErr = 1;
                else begin
                    mOut--;
                    mFifo.push_back(phyRdData);
                end
            end
            if (mIssueRd) mOut++;
            if (mLoad) begin
                mCmdValid = mWrAcc || mRdAcc;
                if (mWrAcc) begin
                    mCmdWr = 1; mCmdAddr = wrAddr; mCmdData = wrData;
                end else if (mRdAcc) begin
                    mCmdWr = 0; mCmdAddr = rdAddr;
                end
            end
        end
    end

    int base;

    initial begin
        rst_n = 0; wrValid = 0; rdValid = 0; wrAddr = '0; rdAddr = '0; wrData = '0;
        rdretReady = 0; phyCmdReady = 0; phyRdVld = 0; phyRdData = '0;
        repeat (3) tick();
        checkOutput("reset_cmd_valid", phyCmdValid, 0);
        checkOutput("reset_wr_ready", wrReady, 0);
        checkOutput("reset_rd_ready", rdReady, 0);
        rst_n = 1;
        tick();
        checkOutput("idle_wr_ready", wrReady, 1);
        checkOutput("idle_rd_ready", rdReady, 1);

        $display("[TB] write-only burst");
        phyCmdReady = 1;
        base = logAddr.size();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, i, 0, 0);
            if (i == 0) begin
                checkOutput("burst_first_valid", phyCmdValid, 1);
                checkOutput("burst_first_addr", phyCmdAddr, 0);
                checkOutput("burst_first_wr", phyCmdWr, 1);
            end
        end
        applyStimulus(0, 0, 0, 0);
        tick();
        checkOutput("burst_count", logAddr.size() - base, 10);
        for (int k = 0; k < 10; k++) begin
            if (base + k < logAddr.size()) begin
                checkOutput("burst_addr", logAddr[base+k], k);
                checkOutput("burst_is_wr", logWr[base+k], 1);
                checkOutput("burst_no_bubble", logCyc[base+k] - logCyc[base], k);
            end
        end

        $display("[TB] contention");
        base = logAddr.size();
        for (int i = 0; i < 6; i++) applyStimulus(1, 100 + i, 1, 200 + i);
        applyStimulus(0, 0, 0, 0);
        tick();
        checkOutput("contend_count", logAddr.size() - base, 6);
        for (int k = 0; k < 6; k++) begin
            if (base + k < logAddr.size()) begin
                checkOutput("contend_kind", logWr[base+k], (k % 2) == 0);
                checkOutput("contend_addr", logAddr[base+k], ((k % 2) == 0) ? 100 + k : 200 + k);
            end
        end
        rdretReady = 1;
        for (int j = 0; j < 3; j++) begin
            phyRdVld = 1; phyRdData = pat(300 + j);
            tick();
        end
        phyRdVld = 0;
        repeat (3) tick();
        checkOutput("contend_drained", rdretValid, 0);

        $display("[TB] credit limit");
        rdretReady = 0;
        base = logAddr.size();
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 1, 400 + i);
        checkOutput("credit_reads", logAddr.size() - base, DEPTH);
        checkOutput("credit_rd_ready", rdReady, 0);
        phyRdVld = 1; phyRdData = pat(500);
        tick();
        phyRdVld = 0; rdretReady = 1;
        tick();
        rdretReady = 0;
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 420 + i);
        applyStimulus(0, 0, 0, 0);
        checkOutput("credit_one_more", logAddr.size() - base, DEPTH + 1);

        $display("[TB] fifo fill and push+pop");
        for (int j = 0; j < 8; j++) begin
            phyRdVld = 1; phyRdData = pat(600 + j);
            tick();
        end
        phyRdVld = 0;
        tick();
        checkOutput("full_rd_ready", rdReady, 0);
        checkOutput("full_head", rdretData, pat(600));
        rdretReady = 1;
        tick();
        rdretReady = 0;
        applyStimulus(0, 0, 1, 700);
        applyStimulus(0, 0, 0, 0);
        phyRdVld = 1; phyRdData = pat(800); rdretReady = 1;
        tick();
        phyRdVld = 0;
        checkOutput("pushpop_head", rdretData, pat(602));
        repeat (10) tick();
        checkOutput("pushpop_drained", rdretValid, 0);

        $display("[TB] spurious return");
        rdretReady = 0;
        phyRdVld = 1; phyRdData = pat(900);
        tick();
        phyRdVld = 0;
        tick();
        checkOutput("spurious_err", errUnexp, 1);
        checkOutput("spurious_no_push", rdretValid, 0);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1000 + i);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        phyCmdReady = 0;
        applyStimulus(1, 55, 0, 0);
        checkOutput("premid_cmd_valid", phyCmdValid, 1);
        rst_n = 0;
        #1;
        checkOutput("midrst_cmd_valid", phyCmdValid, 0);
        checkOutput("midrst_rdret_valid", rdretValid, 0);
        checkOutput("midrst_err", errUnexp, 0);
        checkOutput("midrst_wr_ready", wrReady, 0);
        wrValid = 0; phyCmdReady = 1;
        repeat (2) tick();
        rst_n = 1;
        tick();
        base = logAddr.size();
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 1, 1100 + i);
        applyStimulus(0, 0, 0, 0);
        checkOutput("postrst_credit", logAddr.size() - base, DEPTH);
        checkOutput("postrst_err", errUnexp, 0);

        $display("[TB] %0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
